mult_sequencer: RTL and testbench

Upstream operand sequencer for the successive-addition `multiplier`. It buffers operand pairs from a producer in a small FIFO and issues them one at a time over the multiplier's req/rdy handshake. It captures each product on `done` and presents it downstream with a sequence tag over a valid/ready handshake. It also monitors the multiplier for hung transactions.

---
 rtl/mult_sequencer.sv | 149 ++++++++++++++
 tb/tb_mult_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Operand sequencer for the successive-addition multiplier.
// Queues operand pairs, issues one at a time, tags and holds each result.
module mult_sequencer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mul_req,
  input  logic               mul_rdy,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_ab,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_ab,
  output logic [TAG_W-1:0]   out_tag,
  output logic               err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = WIDTH + 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'((2**WIDTH) + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]   mem_a [DEPTH];
  logic [WIDTH-1:0]   mem_b [DEPTH];
  logic [TAG_W-1:0]   mem_t [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [TAG_W-1:0]   tag_q, cur_tag;
  logic [TW-1:0]      tcnt;
  logic               mul_req_q, out_valid_q, err_q;
  logic [2*WIDTH-1:0] out_ab_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic               push, pop, nonempty;

  assign in_ready = (count != FULL);
  assign nonempty = (count != '0);
  assign push     = in_valid & in_ready;
  assign pop      = (state == S_ISSUE) & mul_rdy;

  assign mul_req   = mul_req_q;
  assign mul_a     = mul_req_q ? mem_a[rd_ptr] : '0;
  assign mul_b     = mul_req_q ? mem_b[rd_ptr] : '0;
  assign out_valid = out_valid_q;
  assign out_ab    = out_ab_q;
  assign out_tag   = out_tag_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (nonempty) state_n = S_ISSUE;
      S_ISSUE: if (mul_rdy) state_n = S_WAIT;
      S_WAIT:  if (mul_done) state_n = S_HOLD;
      S_HOLD:
        if (out_ready)
          state_n = nonempty ? S_ISSUE : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Payload storage carries no reset; reads are gated by mul_req.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
      mem_t[wr_ptr] <= tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_q   <= '0;
      cur_tag <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        tag_q  <= tag_q + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        cur_tag <= mem_t[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_ab_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      mul_req_q   <= (state_n == S_ISSUE);
      out_valid_q <= (state_n == S_HOLD);
      if (state == S_WAIT && mul_done) begin
        out_ab_q  <= mul_ab;
        out_tag_q <= cur_tag;
      end
    end
  end

  // Watchdog: counting stops once the flag is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (pop)
        tcnt <= '0;
      else if (state == S_WAIT && !err_q)
        tcnt <= tcnt + 1'b1;
      if (state == S_WAIT && !mul_done && tcnt == T_LAST)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural
// successive-addition multiplier model.
module tb_mult_sequencer;

  localparam int WIDTH = 5;
  localparam int TAG_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a = '0;
  logic [WIDTH-1:0]   in_b = '0;
  logic               mul_req;
  logic               mul_rdy;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_done = 1'b0;
  logic [2*WIDTH-1:0] mul_ab = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [2*WIDTH-1:0] out_ab;
  logic [TAG_W-1:0]   out_tag;
  logic               err;

  int checks = 0;
  int errors = 0;

  mult_sequencer #(.WIDTH(WIDTH), .DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .mul_req(mul_req), .mul_rdy(mul_rdy),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_ab(mul_ab),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ab(out_ab), .out_tag(out_tag),
    .err(err)
  );

  always #5 clk = ~clk;

  // Multiplier model: start at req&rdy, done pulse after edge start+a.
  logic               busy = 1'b0;
  logic               hang = 1'b0;
  logic [WIDTH-1:0]   cnt = '0;
  logic [WIDTH-1:0]   mb = '0;
  logic [2*WIDTH-1:0] acc = '0;

  assign mul_rdy = !busy;

  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
    end else if (!busy && mul_req) begin
      if (hang) begin
        busy <= 1'b1;
      end else if (mul_a == '0) begin
        mul_done <= 1'b1;
        mul_ab   <= '0;
      end else begin
        busy <= 1'b1;
        cnt  <= mul_a;
        mb   <= mul_b;
        acc  <= '0;
      end
    end else if (busy && !hang) begin
      acc <= acc + {{WIDTH{1'b0}}, mb};
      cnt <= cnt - 1'b1;
      if (cnt == 1) begin
        busy     <= 1'b0;
        mul_done <= 1'b1;
        mul_ab   <= acc + {{WIDTH{1'b0}}, mb};
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic push_one(input int a, input int b);
    int g;
    bit ok;
    bit sent;
    in_valid = 1'b1;
    in_a = WIDTH'(a);
    in_b = WIDTH'(b);
    sent = 0;
    g = 0;
    while (!sent && g < 300) begin
      ok = in_ready;
      tick;
      if (ok) sent = 1;
      g++;
    end
    in_valid = 1'b0;
    if (!sent) begin
      checks++;
      errors++;
      $display("FAIL push_timeout got in_ready=0 want 1");
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 5'd3;
    in_b = 5'd3;
    tick;
    checks++;
    if (in_ready !== 1'b1 || mul_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got rdy=%b req=%b want 1 0",
               in_ready, mul_req);
    end
    checks++;
    if (mul_a !== '0 || mul_b !== '0) begin
      errors++;
      $display("FAIL reset_mul got a=%0d b=%0d want 0 0",
               mul_a, mul_b);
    end
    checks++;
    if (out_valid !== 1'b0 || out_ab !== '0 ||
        out_tag !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got v=%b ab=%0d tag=%0d err=%b want 0",
               out_valid, out_ab, out_tag, err);
    end
    in_valid = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (mul_req !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_push_dropped got req=%b rdy=%b want 0 1",
               mul_req, in_ready);
    end
  endtask

  task automatic test_single;
    int n;
    do_reset;
    push_one(3, 7);
    wait_valid(n);
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL single_latency got %0d want 6", n);
    end
    checks++;
    if (out_ab !== 10'd21 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL single_data got ab=%0d tag=%0d want 21 0",
               out_ab, out_tag);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_corner;
    int n;
    do_reset;
    push_one(0, 31);
    wait_valid(n);
    checks++;
    if (n != 3 || out_ab !== 10'd0) begin
      errors++;
      $display("FAIL corner_zero got n=%0d ab=%0d want 3 0", n, out_ab);
    end
    tick;
    push_one(31, 31);
    wait_valid(n);
    checks++;
    if (n != 34 || out_ab !== 10'd961 || out_tag !== 4'd1) begin
      errors++;
      $display("FAIL corner_max got n=%0d ab=%0d tag=%0d want 34 961 1",
               n, out_ab, out_tag);
    end
    tick;
  endtask

  task automatic test_backpressure;
    int n;
    int k;
    int g;
    do_reset;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_one(i, i);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got in_ready=%b want 0", in_ready);
    end
    wait_valid(n);
    checks++;
    if (out_ab !== 10'd1 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL bp_first got ab=%0d tag=%0d want 1 0",
               out_ab, out_tag);
    end
    repeat (4) tick;
    checks++;
    if (out_valid !== 1'b1 || out_ab !== 10'd1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got v=%b ab=%0d rdy=%b want 1 1 0",
               out_valid, out_ab, in_ready);
    end
    out_ready = 1'b1;
    k = 0;
    g = 0;
    while (k < 5 && g < 200) begin
      if (out_valid) begin
        checks++;
        if (out_ab !== 10'((k + 1) * (k + 1)) || out_tag !== 4'(k)) begin
          errors++;
          $display("FAIL bp_drain got ab=%0d tag=%0d want %0d %0d",
                   out_ab, out_tag, (k + 1) * (k + 1), k);
        end
        k++;
      end
      tick;
      g++;
    end
    checks++;
    if (k != 5) begin
      errors++;
      $display("FAIL bp_count got %0d want 5", k);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    do_reset;
    k = 0;
    fork
      begin
        for (int i = 0; i < 18; i++) push_one(2, 3);
      end
      begin
        int g;
        g = 0;
        while (k < 18 && g < 400) begin
          if (out_valid) begin
            checks++;
            if (out_ab !== 10'd6 || out_tag !== 4'(k % 16)) begin
              errors++;
              $display("FAIL b2b_result got ab=%0d tag=%0d want 6 %0d",
                       out_ab, out_tag, k % 16);
            end
            k++;
          end
          tick;
          g++;
        end
      end
    join
    checks++;
    if (k != 18) begin
      errors++;
      $display("FAIL b2b_count got %0d want 18", k);
    end
  endtask

  task automatic test_reset_wait;
    int n;
    bit seen;
    do_reset;
    push_one(20, 5);
    push_one(1, 1);
    push_one(1, 1);
    repeat (3) tick;
    rst = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0 || out_ab !== '0 || out_tag !== '0 ||
        err !== 1'b0 || mul_req !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_state got v=%b ab=%0d tag=%0d err=%b req=%b rdy=%b",
               out_valid, out_ab, out_tag, err, mul_req, in_ready);
    end
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      tick;
      if (out_valid || mul_req) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstwait_quiet got activity=1 want 0");
    end
    push_one(2, 2);
    wait_valid(n);
    checks++;
    if (out_valid !== 1'b1 || out_ab !== 10'd4 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL rstwait_new got v=%b ab=%0d tag=%0d want 1 4 0",
               out_valid, out_ab, out_tag);
    end
    tick;
  endtask

  task automatic test_timeout;
    int n;
    do_reset;
    hang = 1'b1;
    push_one(1, 1);
    n = 0;
    while (!err && n < 100) begin
      tick;
      n++;
    end
    checks++;
    if (n != 36) begin
      errors++;
      $display("FAIL timeout_latency got %0d want 36", n);
    end
    repeat (20) tick;
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky got err=%b v=%b want 1 0",
               err, out_valid);
    end
    rst = 1'b1;
    tick;
    hang = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got err=%b want 0", err);
    end
    rst = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_corner;
    test_backpressure;
    test_back_to_back;
    test_reset_wait;
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
